// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised pipeline stage register with valid, flush, forwarding and perf counters
//
// Purpose:
//   Edge-triggered register placed between two pipeline stages. Each cycle it
//   loads, holds, or replaces its contents with a bubble, depending on the
//   global stall vector and the flush input. It exposes a forwarding compare
//   for its pending register write, and it counts hold cycles and inserted
//   bubbles with saturating counters.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall           global stall vector (bit i stalls stage i)
//   flush           replace the incoming instruction with a bubble
//   in_*            upstream instruction fields
//   out_*           registered instruction fields
//   fwd_num         register number queried by the forwarding unit
//   fwd_hit/data    pending-write match and its value
//   hold_cnt        saturating count of HOLD cycles
//   bubble_cnt      saturating count of bubbles inserted by stall or flush
//   cnt_clr         synchronous clear of both counters

module pipe_stage_reg #(
    parameter int DATA_W    = 32,
    parameter int OP_W      = 5,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 3,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [OP_W-1:0]    in_op,
    input  logic [4:0]         in_wnum,
    input  logic               in_wreg,
    input  logic [DATA_W-1:0]  in_wdata,
    input  logic [DATA_W-1:0]  in_addr,
    input  logic [DATA_W-1:0]  in_sdata,
    output logic               out_valid,
    output logic [OP_W-1:0]    out_op,
    output logic [4:0]         out_wnum,
    output logic               out_wreg,
    output logic [DATA_W-1:0]  out_wdata,
    output logic [DATA_W-1:0]  out_addr,
    output logic [DATA_W-1:0]  out_sdata,
    input  logic [4:0]         fwd_num,
    output logic               fwd_hit,
    output logic [DATA_W-1:0]  fwd_data,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic [CNT_W-1:0]   bubble_cnt,
    input  logic               cnt_clr
);

    // The register needs the stall bit of the stage after its input stage,
    // so STAGE_IDX+1 must still fall inside the stall vector.
    generate
        if (STAGE_IDX > STALL_W - 2) begin : g_bad_stage_idx
            $error("pipe_stage_reg: STAGE_IDX must be in 0..STALL_W-2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_FLUSH  = 2'd3
    } act_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic               s_in;
    logic               s_out;
    act_e               act;

    logic               valid_q, valid_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [4:0]         wnum_q, wnum_d;
    logic               wreg_q, wreg_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  sdata_q, sdata_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;

    assign s_in  = stall[STAGE_IDX];
    assign s_out = stall[STAGE_IDX+1];

    // Action select. The stall controller never sends s_in=0 with s_out=1.
    // If it does, the register still loads, so the input stage cannot lose
    // an instruction.
    always_comb begin
        act = ACT_LOAD;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (s_in && !s_out) begin
            act = ACT_BUBBLE;
        end else if (s_in && s_out) begin
            act = ACT_HOLD;
        end
    end

    always_comb begin
        valid_d      = valid_q;
        op_d         = op_q;
        wnum_d       = wnum_q;
        wreg_d       = wreg_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        sdata_d      = sdata_q;
        hold_cnt_d   = hold_cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        case (act)
            ACT_FLUSH, ACT_BUBBLE: begin
                valid_d = 1'b0;
                op_d    = '0;
                wnum_d  = '0;
                wreg_d  = 1'b0;
                wdata_d = '0;
                addr_d  = '0;
                sdata_d = '0;
                if (bubble_cnt_q != CNT_MAX) begin
                    bubble_cnt_d = bubble_cnt_q + 1'b1;
                end
            end
            ACT_HOLD: begin
                if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                // An invalid upstream slot loads as all-zero fields. It is not
                // counted as a bubble because this register did not insert it.
                valid_d = in_valid;
                op_d    = in_valid ? in_op    : '0;
                wnum_d  = in_valid ? in_wnum  : '0;
                wdata_d = in_valid ? in_wdata : '0;
                addr_d  = in_valid ? in_addr  : '0;
                sdata_d = in_valid ? in_sdata : '0;
                // Writes to r0 are squashed here, so downstream never sees them.
                wreg_d  = in_wreg && in_valid && (in_wnum != 5'd0);
            end
        endcase

        if (cnt_clr) begin
            hold_cnt_d   = '0;
            bubble_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            op_q         <= '0;
            wnum_q       <= '0;
            wreg_q       <= 1'b0;
            wdata_q      <= '0;
            addr_q       <= '0;
            sdata_q      <= '0;
            hold_cnt_q   <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            op_q         <= op_d;
            wnum_q       <= wnum_d;
            wreg_q       <= wreg_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
            sdata_q      <= sdata_d;
            hold_cnt_q   <= hold_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_op     = op_q;
    assign out_wnum   = wnum_q;
    assign out_wreg   = wreg_q;
    assign out_wdata  = wdata_q;
    assign out_addr   = addr_q;
    assign out_sdata  = sdata_q;
    assign hold_cnt   = hold_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

    assign fwd_hit  = valid_q && wreg_q && (wnum_q == fwd_num) && (fwd_num != 5'd0);
    assign fwd_data = fwd_hit ? wdata_q : '0;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised, clocked pipeline register for the five-stage core. It is the generic successor to the per-stage latch blocks and can be instantiated at any stage boundary through STAGE_IDX. It adds the following over the per-stage latches:
- true edge-triggered state
- a valid bit
- explicit flush
- r0 write suppression
- a forwarding-compare port
- saturating hold and bubble performance counters

Parameters:
DATA_W, 32, width of each data field (result data, address, store operand)
OP_W, 5, width of ALU opcode field
STALL_W, 6, width of the global stall vector
STAGE_IDX, 3, stall bit owning this register's input stage; legal range 0..STALL_W-2
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  STALL_W  global stall vector; bit i=1 stalls stage i
flush  in  1  discard the upstream instruction and load a bubble
in_valid  in  1  upstream instruction valid
in_op  in  OP_W  upstream ALU opcode
in_wnum  in  5  upstream destination register number
in_wreg  in  1  upstream register-write enable
in_wdata  in  DATA_W  upstream write-back data
in_addr  in  DATA_W  upstream memory address
in_sdata  in  DATA_W  upstream store operand
out_valid  out  1  registered valid
out_op  out  OP_W  registered opcode
out_wnum  out  5  registered destination number
out_wreg  out  1  registered write enable
out_wdata  out  DATA_W  registered write-back data
out_addr  out  DATA_W  registered address
out_sdata  out  DATA_W  registered store operand
fwd_num  in  5  register number queried by the forwarding unit
fwd_hit  out  1  this stage holds a pending write to fwd_num
fwd_data  out  DATA_W  forwarding value
hold_cnt  out  CNT_W  cycles spent in HOLD
bubble_cnt  out  CNT_W  bubbles inserted by stall or flush
cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- All state updates on the rising edge of clk only; there are no latches.
- Let s_in = stall[STAGE_IDX] and s_out = stall[STAGE_IDX+1].
- Per-cycle action, first match wins:
  1. RESET (rst=1): every out_* = 0, hold_cnt = 0, bubble_cnt = 0.
  2. FLUSH (flush=1): load a bubble. All out_* = 0, out_valid = 0. bubble_cnt increments. Flush overrides any stall.
  3. BUBBLE (s_in=1, s_out=0): the upstream stage is stalled but downstream advances. Load a bubble with all out_* = 0. bubble_cnt increments.
  4. HOLD (s_in=1, s_out=1): all out_* keep their values. hold_cnt increments.
  5. LOAD (s_in=0): out_* <= in_* with one-cycle latency.
     - out_valid <= in_valid.
     - out_wreg <= in_wreg & in_valid & (in_wnum != 0), so writes to r0 are never propagated.
     - If in_valid=0, load all-zero fields, identical to a bubble. This does not increment bubble_cnt.
- s_in=0 with s_out=1 is illegal from the stall controller. In that case the block performs LOAD.
- Counters:
  - Saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 zeroes both counters, overriding any increment in the same cycle.
  - rst has priority over cnt_clr.
- Forwarding output is combinational from the registers and fwd_num:
  - fwd_hit = out_valid & out_wreg & (out_wnum == fwd_num) & (fwd_num != 0).
  - fwd_data = out_wdata when fwd_hit=1, else 0.
- Reset mid-HOLD drops the held instruction. The first post-reset cycle behaves per the stall and flush inputs.
- Elaboration must fail (generate-time error) if STAGE_IDX > STALL_W-2.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with nonzero inputs -> all outputs 0 and both counters 0 after the first edge.
2. Load: stall=0, in_valid=1, in_wnum=8, in_wreg=1, in_wdata=0xDEADBEEF -> one edge later out_valid=1, out_wnum=8, out_wdata=0xDEADBEEF. With fwd_num=8 -> fwd_hit=1 and fwd_data=0xDEADBEEF. With fwd_num=9 -> fwd_hit=0.
3. Hold then bubble:
   - Load 0x1234, then apply stall=6'b011000 for 3 cycles -> outputs stay 0x1234 and hold_cnt=3.
   - Then apply stall=6'b001000 -> next edge out_valid=0, all fields 0, bubble_cnt=1.
4. Flush priority: stall=6'b011000 with flush=1 and a valid entry held -> next edge all outputs 0, bubble_cnt increments, hold_cnt unchanged.
5. r0 suppression: in_wnum=0, in_wreg=1, in_valid=1, stall=0 -> out_wreg=0 and out_valid=1. With fwd_num=0 -> fwd_hit=0.
6. Counter saturation and clear:
   - CNT_W=2 with 5 HOLD cycles -> hold_cnt=3.
   - cnt_clr=1 in the same cycle as a HOLD -> hold_cnt=0.
   - rst=1 together with cnt_clr=1 -> both counters 0.
